// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port data-RAM arbiter between the core's memory stage and a camera FIFO writer.
// Optional feature macro MEM_ARB_FB_PROTECT_EN: block CPU stores into the frame-buffer region.
module mem_arbiter #(
    parameter int unsigned AW          = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CAM_BASE    = 32'h0000_8000,
    parameter int unsigned FRAME_WORDS = 4800
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          cam_valid,
    input  logic [31:0]   cam_data,
    output logic          cam_ready,
    input  logic          cam_frame_start,
    output logic          frame_done,
    output logic          cam_overflow,
    output logic          fb_violation,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FORCE = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_EXIT  = CNT_W'(FIFO_DEPTH / 2 + 1);
    localparam logic [AW-1:0]    ADDR_BASE = AW'(CAM_BASE);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(CAM_BASE + FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, CAM_FORCE} state_t;

    state_t           state, state_nxt;
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, wr_idx;
    logic [CNT_W-1:0] count;
    logic [AW-1:0]    cam_addr;
    logic [AW-1:0]    cpu_word;
    logic             cpu_fb_hit;
    logic             cam_grant, cam_write, cpu_wr_grant, cpu_rd_grant;
    logic             push, pop, stall_int, we_int;
    logic             unused_addr_bits;

    assign cpu_word         = cpu_addr[AW+1:2];
    assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

`ifdef MEM_ARB_FB_PROTECT_EN
    assign cpu_fb_hit = (32'(cpu_word) >= CAM_BASE) && (32'(cpu_word) < CAM_BASE + FRAME_WORDS);
`else
    assign cpu_fb_hit = 1'b0;
`endif

    assign cam_ready = (count != CNT_FULL);
    assign push      = cam_valid && cam_ready;
    assign cam_write = cam_grant && !cam_frame_start;
    assign pop       = cam_write;
    assign wr_idx    = cam_frame_start ? '0 : wr_ptr;

    // Port scheduling: forced camera drain, then CPU, then idle-slot camera writes
    always_comb begin
        state_nxt    = state;
        cam_grant    = 1'b0;
        cpu_wr_grant = 1'b0;
        cpu_rd_grant = 1'b0;
        stall_int    = 1'b0;
        cpu_rdata    = '0;
        case (state)
            IDLE: begin
                if (count >= CNT_FORCE) begin
                    cam_grant = 1'b1;
                    stall_int = cpu_req;
                    state_nxt = CAM_FORCE;
                end else if (cpu_req && cpu_we) begin
                    cpu_wr_grant = 1'b1;
                end else if (cpu_req) begin
                    cpu_rd_grant = 1'b1;
                    stall_int    = 1'b1;
                    state_nxt    = RD_WAIT;
                end else if (count != '0) begin
                    cam_grant = 1'b1;
                end
            end
            RD_WAIT: begin
                cpu_rdata = mem_rdata;
                cam_grant = (count != '0);
                state_nxt = IDLE;
            end
            CAM_FORCE: begin
                cam_grant = (count != '0);
                stall_int = cpu_req;
                // count+push <= DEPTH/2+1 is "post-pop count <= DEPTH/2" without underflow
                if (cam_frame_start || ((count + CNT_W'(push)) <= CNT_EXIT))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RAM port mux driven straight from the grant
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        we_int    = 1'b0;
        if (cam_grant) begin
            mem_addr  = cam_addr;
            mem_wdata = fifo_mem[rd_ptr];
            we_int    = cam_write;
        end else if (cpu_wr_grant) begin
            mem_addr  = cpu_word;
            mem_wdata = cpu_wdata;
            we_int    = !cpu_fb_hit;
        end else if (cpu_rd_grant) begin
            mem_addr  = cpu_word;
        end
    end

    assign mem_we    = we_int && reset;
    assign cpu_stall = stall_int && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_idx] <= cam_data;
    end

    // FIFO pointers; a frame restart empties the FIFO but keeps a same-cycle word as entry 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (cam_frame_start) begin
            rd_ptr <= '0;
            wr_ptr <= PTR_W'(push);
            count  <= CNT_W'(push);
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(push);
            count  <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cam_addr     <= ADDR_BASE;
            frame_done   <= 1'b0;
            cam_overflow <= 1'b0;
        end else begin
            frame_done <= cam_write && (cam_addr == ADDR_LAST);
            if (cam_frame_start)
                cam_addr <= ADDR_BASE;
            else if (cam_write)
                cam_addr <= (cam_addr == ADDR_LAST) ? ADDR_BASE : cam_addr + AW'(1);
            if (cam_frame_start)
                cam_overflow <= 1'b0;
            else if (cam_valid && !cam_ready)
                cam_overflow <= 1'b1;
        end
    end

`ifdef MEM_ARB_FB_PROTECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         fb_violation <= 1'b0;
        else if (cpu_wr_grant && cpu_fb_hit) fb_violation <= 1'b1;
    end
`else
    assign fb_violation = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a queue-based reference model.
module tb_mem_arbiter;
    localparam int unsigned AW   = 16;
    localparam int unsigned D    = 4;
    localparam int unsigned BASE = 32'h0000_8000;
    localparam int unsigned FW   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          cam_valid, cam_ready, cam_frame_start;
    logic [31:0]   cam_data;
    logic          frame_done, cam_overflow, fb_violation;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_we;

    mem_arbiter #(.AW(AW), .FIFO_DEPTH(D), .CAM_BASE(BASE), .FRAME_WORDS(FW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cam_valid(cam_valid), .cam_data(cam_data), .cam_ready(cam_ready),
        .cam_frame_start(cam_frame_start), .frame_done(frame_done),
        .cam_overflow(cam_overflow), .fb_violation(fb_violation),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: registered read, read-before-write
    logic [31:0] env_ram [0:65535];
    always @(posedge clk) begin
        mem_rdata <= env_ram[mem_addr];
        if (mem_we) env_ram[mem_addr] <= mem_wdata;
    end

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] q[$];
    logic [31:0] exp_ram [0:65535];
    bit          m_rd, m_force, m_done, m_ovf, m_fbv;
    int          m_ptr;
    logic [31:0] m_rdval;
    // Per-cycle expectations
    bit          e_we, e_stall, e_ready, e_cam_go, e_cpu_wr, e_cpu_rd, e_addr_chk;
    logic [15:0] e_addr;
    logic [31:0] e_wdata, e_rdata;

    task automatic reset_model();
        q.delete();
        m_rd = 0; m_force = 0; m_done = 0; m_ovf = 0; m_fbv = 0;
        m_ptr = 0; m_rdval = '0;
    endtask

    function automatic int cpu_word_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h0000_FFFF);
    endfunction

    task automatic eval_model();
        int  word;
        bit  hit;
        word = cpu_word_of(cpu_addr);
        hit  = 0;
`ifdef MEM_ARB_FB_PROTECT_EN
        hit = (word >= int'(BASE)) && (word < int'(BASE + FW));
`endif
        e_cam_go = 0; e_cpu_wr = 0; e_cpu_rd = 0; e_stall = 0; e_rdata = '0;
        e_ready = (q.size() != int'(D));
        if (m_rd) begin
            e_rdata  = m_rdval;
            e_cam_go = (q.size() > 0);
        end else if (m_force) begin
            e_cam_go = (q.size() > 0);
            e_stall  = cpu_req;
        end else if (q.size() >= int'(D) - 1) begin
            e_cam_go = 1;
            e_stall  = cpu_req;
        end else if (cpu_req && cpu_we) begin
            e_cpu_wr = 1;
        end else if (cpu_req) begin
            e_cpu_rd = 1;
            e_stall  = 1;
        end else if (q.size() > 0) begin
            e_cam_go = 1;
        end
        e_we = 0; e_addr = '0; e_wdata = '0; e_addr_chk = 0;
        if (e_cam_go) begin
            e_we = !cam_frame_start; e_addr = 16'(int'(BASE) + m_ptr);
            e_wdata = q[0]; e_addr_chk = e_we;
        end else if (e_cpu_wr) begin
            e_we = !hit; e_addr = 16'(word); e_wdata = cpu_wdata; e_addr_chk = 1;
        end else if (e_cpu_rd) begin
            e_addr = 16'(word); e_addr_chk = 1;
        end
    endtask

    task automatic update_model();
        int word, sz, post;
        bit push, enter;
        word  = cpu_word_of(cpu_addr);
        sz    = q.size();
        push  = cam_valid && e_ready;
        enter = !m_rd && !m_force && (sz >= int'(D) - 1);
        post  = sz - (e_cam_go ? 1 : 0) + (push ? 1 : 0);
        m_done = 0;
        if (e_cpu_wr) begin
            if (e_we) exp_ram[word] = cpu_wdata;
            else      m_fbv = 1;
        end
        if (e_cpu_rd) m_rdval = exp_ram[word];
        if (cam_frame_start) begin
            q.delete(); m_ptr = 0; m_ovf = 0;
            if (push) q.push_back(cam_data);
        end else begin
            if (e_cam_go) begin
                exp_ram[int'(BASE) + m_ptr] = q.pop_front();
                if (m_ptr == int'(FW) - 1) begin m_ptr = 0; m_done = 1; end
                else m_ptr++;
            end
            if (push) q.push_back(cam_data);
            if (cam_valid && !e_ready) m_ovf = 1;
        end
        m_force = enter || (m_force && !cam_frame_start && post > int'(D) / 2);
        m_rd    = e_cpu_rd;
    endtask

    task automatic settle();
        @(negedge clk);
        eval_model();
    endtask

    task automatic advance();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        cam_valid = 0; cam_data = '0; cam_frame_start = 0;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        repeat (n) begin settle(); advance(); end
    endtask

    task automatic drive_random(input bit hold);
        int w;
        if (!hold) begin
            cpu_req   = ($urandom_range(0, 1) == 1);
            cpu_we    = ($urandom_range(0, 1) == 1);
            w = ($urandom_range(0, 7) == 0) ? int'(BASE) + int'($urandom_range(0, 5))
                                            : int'($urandom_range(0, 31));
            cpu_addr  = ($urandom() & 32'hFFFC_0003) | (32'(w) << 2);
            cpu_wdata = $urandom();
        end
        cam_valid       = ($urandom_range(0, 9) < 6);
        cam_data        = $urandom();
        cam_frame_start = ($urandom_range(0, 59) == 0);
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (6) begin
            drive_random(0);
            @(negedge clk);
            checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
            checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
            checks++; if (cam_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cam_ready); end
            checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
            @(posedge clk); #1;
        end
        set_idle();
        reset = 1;
        reset_model();
        settle();
        checks++; if ({frame_done, cam_overflow, fb_violation} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {frame_done, cam_overflow, fb_violation}); end
        advance();
    endtask

    task automatic test_store_load();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h5;
        settle();
        checks++; if (mem_addr !== 16'h4 || mem_we !== 1'b1 || mem_wdata !== 32'h5) begin failures++;
            $display("FAIL store addr/we/data got=%h/%b/%h exp=0004/1/00000005", mem_addr, mem_we, mem_wdata); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL store_stall got=%b exp=0", cpu_stall); end
        advance();
        cpu_we = 0;
        settle();
        checks++; if (cpu_stall !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h4) begin failures++;
            $display("FAIL load_issue stall/we/addr got=%b/%b/%h exp=1/0/0004", cpu_stall, mem_we, mem_addr); end
        advance();
        settle();
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL load_wait_stall got=%b exp=0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'h5) begin failures++; $display("FAIL load_data got=%h exp=00000005", cpu_rdata); end
        advance();
        idle_cycles(1);
    endtask

    task automatic test_idle_drain();
        logic [31:0] wa, wb;
        wa = $urandom(); wb = $urandom();
        set_idle();
        for (int c = 0; c < 5; c++) begin
            cam_valid = (c < 2);
            cam_data  = (c == 0) ? wa : wb;
            settle();
            if (c == 1) begin
                checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h8000 || mem_wdata !== wa) begin failures++;
                    $display("FAIL drain_w0 we/addr/data got=%b/%h/%h exp=1/8000/%h", mem_we, mem_addr, mem_wdata, wa); end
            end else if (c == 2) begin
                checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h8001 || mem_wdata !== wb) begin failures++;
                    $display("FAIL drain_w1 we/addr/data got=%b/%h/%h exp=1/8001/%h", mem_we, mem_addr, mem_wdata, wb); end
            end else begin
                checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL drain_idle c=%0d got=%b exp=0", c, mem_we); end
            end
            advance();
        end
    endtask

    task automatic test_forced_drain();
        bit hold;
        hold = 0;
        cpu_req = 1; cpu_we = 1;
        for (int i = 0; i < 8; i++) begin
            if (!hold) begin cpu_addr = 32'(32'h100 + i * 4); cpu_wdata = $urandom(); end
            cam_valid = (i < 3);
            cam_data  = $urandom();
            settle();
            checks++; if (cpu_stall !== ((i == 3) || (i == 4))) begin failures++;
                $display("FAIL force_stall i=%0d got=%b exp=%b", i, cpu_stall, (i == 3) || (i == 4)); end
            checks++; if (mem_we !== 1'b1 || mem_addr !== e_addr) begin failures++;
                $display("FAIL force_port i=%0d we/addr got=%b/%h exp=1/%h", i, mem_we, mem_addr, e_addr); end
            hold = e_stall;
            advance();
        end
        idle_cycles(4);
    endtask

    task automatic test_wrap();
        logic [31:0] w [5];
        int pulses;
        pulses = 0;
        for (int k = 0; k < 5; k++) w[k] = $urandom();
        set_idle();
        cam_frame_start = 1;
        settle(); advance();
        cam_frame_start = 0;
        for (int j = 0; j < 8; j++) begin
            cam_valid = (j < 5);
            cam_data  = (j < 5) ? w[j] : '0;
            settle();
            if (frame_done === 1'b1) pulses++;
            checks++; if (frame_done !== (j == 5)) begin failures++;
                $display("FAIL wrap_done j=%0d got=%b exp=%b", j, frame_done, j == 5); end
            if (j >= 1 && j <= 5) begin
                checks++; if (mem_we !== 1'b1 || mem_addr !== 16'(32'h8000 + (j - 1) % 4) || mem_wdata !== w[j-1]) begin
                    failures++; $display("FAIL wrap_write j=%0d we/addr/data got=%b/%h/%h exp=1/%h/%h",
                        j, mem_we, mem_addr, mem_wdata, 16'(32'h8000 + (j - 1) % 4), w[j-1]); end
            end
            advance();
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL wrap_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_sustained();
        bit hold;
        hold = 0;
        for (int i = 0; i < 40; i++) begin
            if (!hold) begin
                cpu_req = 1; cpu_we = 1;
                cpu_addr = 32'($urandom_range(0, 31)) << 2; cpu_wdata = $urandom();
            end
            cam_valid = 1; cam_data = $urandom(); cam_frame_start = 0;
            settle();
            checks++; if (cam_ready !== 1'b1 || cam_overflow !== 1'b0) begin failures++;
                $display("FAIL sustained i=%0d ready/ovf got=%b/%b exp=1/0", i, cam_ready, cam_overflow); end
            checks++; if (cpu_stall !== e_stall) begin failures++;
                $display("FAIL sustained_stall i=%0d got=%b exp=%b", i, cpu_stall, e_stall); end
            hold = e_stall;
            advance();
        end
        idle_cycles(6);
    endtask

    task automatic test_frame_start();
        logic [31:0] x;
        x = $urandom();
        for (int c = 0; c < 5; c++) begin
            cpu_req = (c < 2); cpu_we = 1; cpu_addr = 32'(32'h200 + c * 4); cpu_wdata = $urandom();
            cam_valid = (c < 3); cam_data = (c == 2) ? x : $urandom();
            cam_frame_start = (c == 2);
            settle();
            if (c == 2) begin
                checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL fs_cancel got=%b exp=0", mem_we); end
            end else if (c == 3) begin
                checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h8000 || mem_wdata !== x) begin failures++;
                    $display("FAIL fs_word0 we/addr/data got=%b/%h/%h exp=1/8000/%h", mem_we, mem_addr, mem_wdata, x); end
            end else if (c == 4) begin
                checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL fs_empty got=%b exp=0", mem_we); end
            end
            advance();
        end
        set_idle();
    endtask

    task automatic test_protect();
        set_idle();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0002_0000; cpu_wdata = 32'hDEAD_BEEF;
        settle();
`ifdef MEM_ARB_FB_PROTECT_EN
        checks++; if (mem_we !== 1'b0 || cpu_stall !== 1'b0) begin failures++;
            $display("FAIL protect_store we/stall got=%b/%b exp=0/0", mem_we, cpu_stall); end
`else
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h8000 || cpu_stall !== 1'b0) begin failures++;
            $display("FAIL protect_pass we/addr/stall got=%b/%h/%b exp=1/8000/0", mem_we, mem_addr, cpu_stall); end
`endif
        advance();
        set_idle();
        settle();
`ifdef MEM_ARB_FB_PROTECT_EN
        checks++; if (fb_violation !== 1'b1) begin failures++; $display("FAIL protect_flag got=%b exp=1", fb_violation); end
`else
        checks++; if (fb_violation !== 1'b0) begin failures++; $display("FAIL protect_flag got=%b exp=0", fb_violation); end
`endif
        advance();
    endtask

    task automatic test_random();
        bit hold;
        hold = 0;
        for (int i = 0; i < 2500; i++) begin
            drive_random(hold);
            settle();
            checks++; if (cpu_stall !== e_stall) begin failures++;
                $display("FAIL rand_stall i=%0d got=%b exp=%b", i, cpu_stall, e_stall); end
            checks++; if (mem_we !== e_we) begin failures++;
                $display("FAIL rand_we i=%0d got=%b exp=%b", i, mem_we, e_we); end
            if (e_addr_chk) begin
                checks++; if (mem_addr !== e_addr) begin failures++;
                    $display("FAIL rand_addr i=%0d got=%h exp=%h", i, mem_addr, e_addr); end
            end
            if (e_we) begin
                checks++; if (mem_wdata !== e_wdata) begin failures++;
                    $display("FAIL rand_wdata i=%0d got=%h exp=%h", i, mem_wdata, e_wdata); end
            end
            checks++; if (cpu_rdata !== e_rdata) begin failures++;
                $display("FAIL rand_rdata i=%0d got=%h exp=%h", i, cpu_rdata, e_rdata); end
            checks++; if (cam_ready !== e_ready) begin failures++;
                $display("FAIL rand_ready i=%0d got=%b exp=%b", i, cam_ready, e_ready); end
            checks++; if ({frame_done, cam_overflow, fb_violation} !== {m_done, m_ovf, m_fbv}) begin failures++;
                $display("FAIL rand_flags i=%0d got=%b exp=%b", i,
                    {frame_done, cam_overflow, fb_violation}, {m_done, m_ovf, m_fbv}); end
            hold = e_stall;
            advance();
        end
        set_idle();
    endtask

    task automatic test_mid_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h300; cpu_wdata = $urandom();
        cam_valid = 1;
        repeat (2) begin cam_data = $urandom(); settle(); advance(); end
        cam_valid = 0;
        reset = 0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (mem_we !== 1'b0 || cpu_stall !== 1'b0) begin failures++;
                $display("FAIL midreset we/stall got=%b/%b exp=0/0", mem_we, cpu_stall); end
            @(posedge clk); #1;
        end
        set_idle();
        reset = 1;
        reset_model();
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if (mem_we !== 1'b0 || cam_ready !== 1'b1) begin failures++;
                $display("FAIL midreset_after c=%0d we/ready got=%b/%b exp=0/1", c, mem_we, cam_ready); end
            advance();
        end
    endtask

    initial begin
        set_idle();
        reset = 0;
        reset_model();
        @(posedge clk); #1;
        test_reset();
        test_store_load();
        test_idle_drain();
        test_forced_drain();
        test_wrap();
        test_sustained();
        test_frame_start();
        test_protect();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
